// File: rtl/mem_bus_responder.sv
// 8080 memory-side responder: decodes the status word at SYNC, inserts WAIT_STATES wait cycles, then serves one read or write.
// RAM read data lands in data_o one clock after SYNC; the CPU is held off only through ready_o during the wait window.
module mem_bus_responder #(
   parameter int MEM_DEPTH   = 4096,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk50M_i,
   input  logic        rst_ni,
   input  logic        sync_i,
   input  logic [7:0]  status_i,
   input  logic [15:0] addr_i,
   input  logic        dbin_i,
   input  logic        wr_ni,
   input  logic [7:0]  data_i,
   output logic [7:0]  data_o,
   output logic        data_oe_o,
   output logic        ready_o,
   output logic        m1_o,
   output logic        addr_err_o
);

   localparam int         AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD_XFER, S_WR_XFER} state_t;

   state_t         state, state_nxt;
   logic [3:0]     cnt, cnt_nxt;
   logic [AW-1:0]  addr_q;
   logic           is_rd_q, in_range_q;
   logic           seen, seen_nxt;
   logic           mem_we;
   logic [7:0]     mem [MEM_DEPTH];

   logic dec_rd, dec_wr, dec_in_range, conflict;
   logic unused_bits;

   assign dec_rd       = status_i[7] & ~status_i[6];
   assign dec_wr       = ~status_i[1] & ~status_i[4] & ~status_i[0];
   assign dec_in_range = {16'd0, addr_i} < 32'(MEM_DEPTH);
   assign conflict     = dbin_i & ~wr_ni;
   assign unused_bits  = ^status_i[3:2];

   // seen marks that the strobe has gone active, so the strobe's release ends the transfer
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      seen_nxt  = seen;
      mem_we    = 1'b0;
      data_oe_o = 1'b0;
      ready_o   = (state != S_WAIT);
      if (sync_i) begin
         seen_nxt = 1'b0;
         if (dec_rd | dec_wr) begin
            cnt_nxt = WS;
            if (WS != 4'd0)
               state_nxt = S_WAIT;
            else
               state_nxt = dec_rd ? S_RD_XFER : S_WR_XFER;
         end else begin
            cnt_nxt   = 4'd0;
            state_nxt = S_IDLE;
         end
      end else begin
         case (state)
            S_WAIT: begin
               cnt_nxt = cnt - 4'd1;
               if (cnt <= 4'd1)
                  state_nxt = is_rd_q ? S_RD_XFER : S_WR_XFER;
            end
            S_RD_XFER: begin
               data_oe_o = dbin_i & wr_ni;
               if (dbin_i)
                  seen_nxt = 1'b1;
               else if (seen)
                  state_nxt = S_IDLE;
            end
            S_WR_XFER: begin
               if (!wr_ni) begin
                  // only the first low clock writes; a colliding DBIN consumes the write
                  if (!seen)
                     mem_we = in_range_q & ~dbin_i;
                  seen_nxt = 1'b1;
               end else if (seen) begin
                  state_nxt = S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk50M_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         seen       <= 1'b0;
         addr_q     <= '0;
         is_rd_q    <= 1'b0;
         in_range_q <= 1'b0;
         data_o     <= 8'h00;
         m1_o       <= 1'b0;
         addr_err_o <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         seen       <= seen_nxt;
         addr_err_o <= 1'b0;
         if (sync_i) begin
            addr_q     <= addr_i[AW-1:0];
            is_rd_q    <= dec_rd;
            in_range_q <= dec_in_range;
            m1_o       <= status_i[5];
            addr_err_o <= (dec_rd | dec_wr) & ~dec_in_range;
            if (dec_rd)
               data_o <= dec_in_range ? mem[addr_i[AW-1:0]] : 8'hFF;
         end else if ((state == S_RD_XFER || state == S_WR_XFER) && conflict) begin
            addr_err_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk50M_i) begin
      if (mem_we)
         mem[addr_q] <= data_i;
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Drives three responders (1, 3 and 0 wait states) with identical bus traffic and checks them against a byte-array memory model.
module tb_mem_bus_responder;

   logic        clk = 1'b0, rst_n = 1'b1, sync = 1'b0, dbin = 1'b0, wr_n = 1'b1;
   logic [7:0]  status = 8'h00, din = 8'h00;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  dout [3];
   logic        oe [3], rdy [3], m1 [3], err [3];

   int errors = 0, checks = 0;

   mem_bus_responder #(.MEM_DEPTH(4096), .WAIT_STATES(1)) u_ws1 (
      .clk50M_i(clk), .rst_ni(rst_n), .sync_i(sync), .status_i(status), .addr_i(addr),
      .dbin_i(dbin), .wr_ni(wr_n), .data_i(din), .data_o(dout[0]), .data_oe_o(oe[0]),
      .ready_o(rdy[0]), .m1_o(m1[0]), .addr_err_o(err[0]));
   mem_bus_responder #(.MEM_DEPTH(4096), .WAIT_STATES(3)) u_ws3 (
      .clk50M_i(clk), .rst_ni(rst_n), .sync_i(sync), .status_i(status), .addr_i(addr),
      .dbin_i(dbin), .wr_ni(wr_n), .data_i(din), .data_o(dout[1]), .data_oe_o(oe[1]),
      .ready_o(rdy[1]), .m1_o(m1[1]), .addr_err_o(err[1]));
   mem_bus_responder #(.MEM_DEPTH(4096), .WAIT_STATES(0)) u_ws0 (
      .clk50M_i(clk), .rst_ni(rst_n), .sync_i(sync), .status_i(status), .addr_i(addr),
      .dbin_i(dbin), .wr_ni(wr_n), .data_i(din), .data_o(dout[2]), .data_oe_o(oe[2]),
      .ready_o(rdy[2]), .m1_o(m1[2]), .addr_err_o(err[2]));

   always #10 clk = ~clk;

   function automatic int ws(input int i);
      return (i == 0) ? 1 : (i == 1) ? 3 : 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // observations of the last bus cycle
   int          lows [3];
   int          errc;
   logic [7:0]  rd [3];
   logic        oe_s [3];
   logic        m1_s;

   task automatic bus_cycle(input logic [7:0] st, input logic [15:0] a, input logic [7:0] wd, input int hold);
      @(negedge clk);
      sync = 1'b1; status = st; addr = a; dbin = 1'b0; wr_n = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      m1_s = m1[0];
      errc = 0;
      for (int i = 0; i < 3; i++) lows[i] = 0;
      repeat (6) begin
         for (int i = 0; i < 3; i++) if (!rdy[i]) lows[i]++;
         if (err[0]) errc++;
         @(negedge clk);
      end
      if (st[1]) begin
         dbin = 1'b1;
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin rd[i] = dout[i]; oe_s[i] = oe[i]; end
         dbin = 1'b0;
         @(negedge clk);
      end else begin
         din = wd; wr_n = 1'b0;
         @(negedge clk);
         din = ~wd;
         repeat (hold - 1) @(negedge clk);
         wr_n = 1'b1;
         @(negedge clk);
      end
   endtask

   logic [7:0] model [int];

   task automatic apply(input string tag, input logic [7:0] st, input logic [15:0] a, input logic [7:0] wd, input int hold);
      logic is_rd, is_wr, srv, inr;
      logic [7:0] exp_rd;
      is_rd  = st[7] & ~st[6];
      is_wr  = ~st[1] & ~st[4] & ~st[0];
      srv    = is_rd | is_wr;
      inr    = (int'(a) < 4096);
      exp_rd = (inr && model.exists(int'(a))) ? model[int'(a)] : 8'hFF;
      bus_cycle(st, a, wd, hold);
      check({tag, "_m1"}, m1_s, st[5]);
      check({tag, "_err"}, errc, (srv && !inr) ? 1 : 0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_lows%0d", tag, i), lows[i], srv ? ws(i) : 0);
         if (st[1]) check($sformatf("%s_oe%0d", tag, i), oe_s[i], is_rd);
         if (st[1] && is_rd) check($sformatf("%s_rd%0d", tag, i), rd[i], exp_rd);
      end
      if (is_wr && !is_rd && inr) model[int'(a)] = wd;
   endtask

   typedef struct {
      logic [7:0]  st;
      logic [15:0] a;
      logic [7:0]  wd;
      int          hold;
      logic [7:0]  exp_rd;
      logic        exp_err;
      logic        exp_srv;
      logic        exp_m1;
   } vec_t;

   vec_t vecs [13];
   int   pool [16];
   logic [7:0] stlist [8];

   initial begin
      #200_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs = '{
         '{8'h00, 16'h0123, 8'hA5, 1, 8'h00, 1'b0, 1'b1, 1'b0},
         '{8'hA2, 16'h0123, 8'h00, 1, 8'hA5, 1'b0, 1'b1, 1'b1},
         '{8'h82, 16'h1000, 8'h00, 1, 8'hFF, 1'b1, 1'b1, 1'b0},
         '{8'h00, 16'h0000, 8'h3C, 1, 8'h00, 1'b0, 1'b1, 1'b0},
         '{8'h00, 16'h2000, 8'h55, 2, 8'h00, 1'b1, 1'b1, 1'b0},
         '{8'h82, 16'h0000, 8'h00, 1, 8'h3C, 1'b0, 1'b1, 1'b0},
         '{8'h04, 16'h0007, 8'h11, 4, 8'h00, 1'b0, 1'b1, 1'b0},
         '{8'h86, 16'h0007, 8'h00, 1, 8'h11, 1'b0, 1'b1, 1'b0},
         '{8'h10, 16'h0007, 8'h99, 2, 8'h00, 1'b0, 1'b0, 1'b0},
         '{8'h82, 16'h0007, 8'h00, 1, 8'h11, 1'b0, 1'b1, 1'b0},
         '{8'h82, 16'hFFFF, 8'h00, 1, 8'hFF, 1'b1, 1'b1, 1'b0},
         '{8'h42, 16'h0007, 8'h00, 1, 8'h00, 1'b0, 1'b0, 1'b0},
         '{8'h23, 16'h0007, 8'h00, 1, 8'h00, 1'b0, 1'b0, 1'b1}
      };
      stlist = '{8'h82, 8'hA2, 8'h86, 8'h00, 8'h04, 8'h10, 8'h42, 8'h23};
      for (int i = 0; i < 16; i++) pool[i] = i * 257;

      // power-on reset
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_ready%0d", i), rdy[i], 1'b1);
         check($sformatf("rst_oe%0d", i), oe[i], 1'b0);
         check($sformatf("rst_data%0d", i), dout[i], 8'h00);
         check($sformatf("rst_m1%0d", i), m1[i], 1'b0);
         check($sformatf("rst_err%0d", i), err[i], 1'b0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // directed table
      for (int v = 0; v < 13; v++) begin
         bus_cycle(vecs[v].st, vecs[v].a, vecs[v].wd, vecs[v].hold);
         check($sformatf("vec%0d_m1", v), m1_s, vecs[v].exp_m1);
         check($sformatf("vec%0d_err", v), errc, vecs[v].exp_err ? 1 : 0);
         for (int i = 0; i < 3; i++) begin
            check($sformatf("vec%0d_lows%0d", v, i), lows[i], vecs[v].exp_srv ? ws(i) : 0);
            if (vecs[v].st[1]) check($sformatf("vec%0d_oe%0d", v, i), oe_s[i], vecs[v].exp_srv);
            if (vecs[v].st[1] && vecs[v].exp_srv)
               check($sformatf("vec%0d_rd%0d", v, i), rd[i], vecs[v].exp_rd);
         end
      end
      model[16'h0123] = 8'hA5;
      model[16'h0000] = 8'h3C;
      model[16'h0007] = 8'h11;

      // reset in the middle of the 3-wait-state window
      @(negedge clk);
      sync = 1'b1; status = 8'hA2; addr = 16'h0123;
      @(negedge clk);
      sync = 1'b0;
      check("midrst_pre_wait", rdy[1], 1'b0);
      check("midrst_pre_m1", m1[1], 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("midrst_ready%0d", i), rdy[i], 1'b1);
         check($sformatf("midrst_oe%0d", i), oe[i], 1'b0);
         check($sformatf("midrst_data%0d", i), dout[i], 8'h00);
         check($sformatf("midrst_m1%0d", i), m1[i], 1'b0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      apply("ram_kept", 8'h82, 16'h0123, 8'h00, 1);

      // fill the random address pool, then randomized traffic
      for (int i = 0; i < 16; i++) apply("init", 8'h00, 16'(pool[i]), 8'($urandom), 1);
      for (int n = 0; n < 40; n++) begin
         logic [15:0] a;
         if ($urandom_range(0, 9) < 8) a = 16'(pool[$urandom_range(0, 15)]);
         else a = 16'($urandom_range(4096, 65535));
         apply($sformatf("rnd%0d", n), stlist[$urandom_range(0, 7)], a, 8'($urandom), $urandom_range(1, 4));
      end

      // write abandoned by a new SYNC before WR_n falls
      @(negedge clk);
      sync = 1'b1; status = 8'h00; addr = 16'(pool[3]);
      @(negedge clk);
      sync = 1'b0; din = 8'h77;
      repeat (5) @(negedge clk);
      apply("abort", 8'h82, 16'(pool[3]), 8'h00, 1);

      // DBIN and WR_n together during a write
      @(negedge clk);
      sync = 1'b1; status = 8'h00; addr = 16'(pool[5]);
      @(negedge clk);
      sync = 1'b0;
      repeat (5) @(negedge clk);
      din = 8'hC3; dbin = 1'b1; wr_n = 1'b0;
      #1 for (int i = 0; i < 3; i++) check($sformatf("wconf_oe%0d", i), oe[i], 1'b0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("wconf_err%0d", i), err[i], 1'b1);
      dbin = 1'b0; wr_n = 1'b1;
      @(negedge clk);
      check("wconf_err_end", err[0], 1'b0);
      apply("wconf_nowrite", 8'h82, 16'(pool[5]), 8'h00, 1);

      // DBIN and WR_n together during a read
      @(negedge clk);
      sync = 1'b1; status = 8'h82; addr = 16'(pool[6]);
      @(negedge clk);
      sync = 1'b0;
      repeat (5) @(negedge clk);
      dbin = 1'b1; wr_n = 1'b0;
      #1 for (int i = 0; i < 3; i++) check($sformatf("rconf_oe%0d", i), oe[i], 1'b0);
      @(negedge clk);
      check("rconf_err", err[0], 1'b1);
      wr_n = 1'b1;
      #1 check("rconf_oe_back", oe[0], 1'b1);
      check("rconf_data", dout[0], model[pool[6]]);
      @(negedge clk);
      dbin = 1'b0;
      @(negedge clk);
      check("rconf_idle_oe", oe[0], 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
